// File: rtl/booth_mult_unit.sv
// Iterative radix-2 Booth multiplier for the EX stage: one Booth step per cycle,
// holding the pipeline with stall until the 64-bit signed product is ready.
module booth_mult_unit #(
  parameter logic [3:0] MULT_CODE = 4'b1000,
  parameter int         WIDTH     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       ALUCnt,
  input  logic             ex_valid,
  input  logic             flush,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [WIDTH:0]       m_reg;
  logic [WIDTH:0]       acc;
  logic [WIDTH-1:0]     q;
  logic                 q_1;
  logic [CW-1:0]        count;
  logic                 start;
  logic                 show;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       acc_nxt;
  logic [WIDTH-1:0]     q_nxt;
  logic [2*WIDTH-1:0]   prod_reg;
  logic [2*WIDTH-1:0]   prod_now;

  // Handshake: stall is asserted combinationally in the start cycle and through
  // every RUN cycle, so IF/ID/EX hold the multiply; it is low in DONE so the
  // instruction advances in the same cycle that done pulses with the product.
  // flush overrides both, dropping stall and done in the cycle it is seen.
  assign start = (state == IDLE) && ex_valid && (ALUCnt == MULT_CODE) && !flush;
  assign stall = start || ((state == RUN) && !flush);
  assign show  = (state == DONE) && !flush;
  assign done  = show;

  assign prod_now           = {acc[WIDTH-1:0], q};
  assign {prod_hi, prod_lo} = show ? prod_now : prod_reg;

  // One Booth step: add/sub on the 33-bit accumulator, then arithmetic shift
  // of {ACC,Q,Q_1}. The extra accumulator bit absorbs -(-2^31).
  always_comb begin
    sum = acc;
    case ({q[0], q_1})
      2'b01:   sum = acc + m_reg;
      2'b10:   sum = acc - m_reg;
      default: sum = acc;
    endcase
    acc_nxt = {sum[WIDTH], sum[WIDTH:1]};
    q_nxt   = {sum[0], q[WIDTH-1:1]};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (flush)              state_nxt = IDLE;
        else if (count == LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_reg <= '0;
      acc   <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      count <= '0;
    end else if (start) begin
      m_reg <= {opA[WIDTH-1], opA};
      acc   <= '0;
      q     <= opB;
      q_1   <= 1'b0;
      count <= '0;
    end else if ((state == RUN) && !flush) begin
      acc   <= acc_nxt;
      q     <= q_nxt;
      q_1   <= q[0];
      count <= count + 1'b1;
    end
  end

  // The visible product is captured only when a DONE cycle completes unflushed.
  always_ff @(posedge clk) begin
    if (rst)       prod_reg <= '0;
    else if (show) prod_reg <= prod_now;
  end

endmodule

// File: tb/tb_booth_mult_unit.sv
// Directed and random bench for booth_mult_unit with an expected-product queue
// filled at start and drained when done pulses.
module tb_booth_mult_unit;

  localparam logic [3:0] MULT = 4'b1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  alu_cnt;
  logic        ex_valid;
  logic        flush;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        stall;
  logic        done;
  logic [31:0] prod_lo;
  logic [31:0] prod_hi;

  logic [63:0] exp_q[$];
  logic [63:0] last_prod;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  booth_mult_unit #(.MULT_CODE(MULT), .WIDTH(32)) dut (
    .clk(clk), .rst(rst), .ALUCnt(alu_cnt), .ex_valid(ex_valid), .flush(flush),
    .opA(op_a), .opB(op_b), .stall(stall), .done(done),
    .prod_lo(prod_lo), .prod_hi(prod_hi)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return sa * sb;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_start(input logic [31:0] a, input logic [31:0] b);
    op_a     = a;
    op_b     = b;
    alu_cnt  = MULT;
    ex_valid = 1'b1;
    #1;
  endtask

  // Full multiply: operands scrambled during RUN must not matter.
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input bit full);
    int cyc;
    int stalls;
    logic [63:0] exp;
    exp_q.push_back(ref_mul(a, b));
    drive_start(a, b);
    if (full) check("start_stall", {63'd0, stall}, 64'd1);
    cyc    = 0;
    stalls = 0;
    while (!done && cyc < 60) begin
      if (stall) stalls++;
      tick();
      cyc++;
      op_a = $urandom;
      op_b = $urandom;
    end
    check("done_seen", {63'd0, done}, 64'd1);
    if (full) begin
      check("latency", 64'(cyc), 64'd33);
      check("stall_cycles", 64'(stalls), 64'd33);
      check("done_stall", {63'd0, stall}, 64'd0);
    end
    exp = exp_q.pop_front();
    check("product", {prod_hi, prod_lo}, exp);
    last_prod = exp;
    ex_valid  = 1'b0;
    alu_cnt   = 4'b0000;
    tick();
    check("done_one_cycle", {63'd0, done}, 64'd0);
    check("prod_hold", {prod_hi, prod_lo}, last_prod);
  endtask

  initial begin
    int seen;
    logic [31:0] ra;
    logic [31:0] rb;

    rst = 1'b1; alu_cnt = 4'b0000; ex_valid = 1'b0; flush = 1'b0;
    op_a = '0; op_b = '0; last_prod = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("reset_stall", {63'd0, stall}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_prod", {prod_hi, prod_lo}, 64'd0);

    run_mult(32'd7, 32'd6, 1'b1);
    check("7x6_lo", {32'd0, prod_lo}, 64'd42);
    check("7x6_hi", {32'd0, prod_hi}, 64'd0);
    run_mult(32'hFFFF_FFFD, 32'd5, 1'b1);
    check("m3x5", {prod_hi, prod_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_mult(32'h8000_0000, 32'h8000_0000, 1'b1);
    check("min_sq", {prod_hi, prod_lo}, 64'h4000_0000_0000_0000);

    // Non-multiply ALU code: ignored.
    alu_cnt = 4'b0000; ex_valid = 1'b1; op_a = 32'd9; op_b = 32'd9;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("other_stall", {63'd0, stall}, 64'd0);
      check("other_done", {63'd0, done}, 64'd0);
      check("other_prod", {prod_hi, prod_lo}, last_prod);
      tick();
    end
    ex_valid = 1'b0;

    // flush coinciding with start in IDLE wins.
    alu_cnt = MULT; ex_valid = 1'b1; flush = 1'b1;
    #1;
    check("idle_flush_stall", {63'd0, stall}, 64'd0);
    tick();
    ex_valid = 1'b0; flush = 1'b0;
    #1;
    check("idle_flush_norun", {63'd0, stall}, 64'd0);
    check("idle_flush_done", {63'd0, done}, 64'd0);

    // flush at RUN cycle 10, then an immediate new multiply.
    drive_start(32'd7, 32'd6);
    repeat (10) tick();
    check("run10_stall", {63'd0, stall}, 64'd1);
    flush = 1'b1;
    #1;
    check("flush_stall", {63'd0, stall}, 64'd0);
    check("flush_done", {63'd0, done}, 64'd0);
    tick();
    check("flush_prod", {prod_hi, prod_lo}, last_prod);
    check("flush_idle_done", {63'd0, done}, 64'd0);
    flush = 1'b0;
    run_mult(32'd2, 32'd3, 1'b1);
    check("2x3", {prod_hi, prod_lo}, 64'd6);

    // flush in the DONE cycle: no pulse, product not updated.
    drive_start(32'd9, 32'd9);
    repeat (33) tick();
    check("pre_flush_done", {63'd0, done}, 64'd1);
    flush = 1'b1;
    #1;
    check("dflush_done", {63'd0, done}, 64'd0);
    check("dflush_stall", {63'd0, stall}, 64'd0);
    check("dflush_prod", {prod_hi, prod_lo}, 64'd6);
    tick();
    ex_valid = 1'b0; flush = 1'b0;
    #1;
    check("dflush_after_prod", {prod_hi, prod_lo}, 64'd6);
    check("dflush_after_done", {63'd0, done}, 64'd0);

    // Reset at RUN cycle 20.
    drive_start(32'd7, 32'd6);
    repeat (20) tick();
    rst = 1'b1; ex_valid = 1'b0; alu_cnt = 4'b0000;
    tick();
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_prod", {prod_hi, prod_lo}, 64'd0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) seen++;
    end
    check("rst_no_done", 64'(seen), 64'd0);
    last_prod = '0;

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 15) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 15) == 0) rb = 32'hFFFF_FFFF;
      run_mult(ra, rb, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
